rect_fill_ctrl: RTL and testbench
=================================

RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high; acts only on the clk rising edge.
REQ-003 SHALL have port start, input, 1, one-cycle fill request; sampled only in IDLE.
REQ-004 SHALL have ports x0[7:0], y0[6:0], input, rectangle top-left corner; sampled with start.
REQ-005 SHALL have ports w[7:0], h[6:0], input, rectangle width and height in pixels; sampled with start.
REQ-006 SHALL have port color_in, input, 3, fill color; sampled with start.
REQ-007 SHALL have port hold, input, 1, stall request from the VGA adapter side.
REQ-008 SHALL have port abort, input, 1, cancels the current fill.
REQ-009 SHALL have ports x[7:0], y[6:0], color[2:0], output, registered pixel coordinate and color.
REQ-010 SHALL have port plot, output, 1, registered pixel write strobe.
REQ-011 SHALL have ports busy and done, output, 1 each; busy is high in any state other than IDLE; done is a one-cycle completion pulse.

Function
REQ-012 SHALL implement the states IDLE, LOAD, DRAW and DONE.
REQ-013 SHALL move IDLE->LOAD on a clock edge with start=1 and abort=0, capturing x0, y0, w, h and color_in at that edge.
REQ-014 SHALL ignore start in every state other than IDLE; captured parameters SHALL stay unchanged until the next accepted start.
REQ-015 SHALL, in LOAD, compute xe=min(x0+w,160) and ye=min(y0+h,120) using 9-bit and 8-bit unsigned arithmetic with no overflow.
REQ-016 SHALL treat the rectangle as empty when w=0, h=0, x0>=160 or y0>=120.
REQ-017 SHALL go LOAD->DONE for an empty rectangle; otherwise LOAD->DRAW, with x=x0, y=y0, color=captured color and plot=1 registered at that edge.
REQ-018 SHALL set the start-to-first-plot latency to exactly 2 clock edges.
REQ-019 SHALL, in DRAW with hold=0, emit one pixel per cycle in raster order (x inner, y outer) over x0..xe-1 and y0..ye-1.
REQ-020 SHALL, at x=xe-1, wrap x to x0 and increment y.
REQ-021 SHALL, on the edge after the pixel (xe-1, ye-1) is plotted, register plot=0 and enter DONE.
REQ-022 SHALL, while hold=1 in DRAW, freeze x, y and the state and drive plot=0; the pending pixel SHALL be emitted in the first cycle after hold falls, so no pixel is skipped or duplicated.
REQ-023 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-024 SHALL, on abort=1 in LOAD, DRAW or DONE, enter IDLE at that edge with plot=0 and busy=0, and SHALL NOT assert done.
REQ-025 SHALL give abort priority over hold and over start.
REQ-026 SHALL never assert plot with x>=160 or y>=120.
REQ-027 SHALL drive plot=0 in IDLE, LOAD and DONE; x, y and color SHALL hold their last values there.

Reset
REQ-028 SHALL, on an edge with reset=1, force state=IDLE, plot=0, done=0, busy=0, x=0, y=0 and color=0, overriding every other input.
REQ-029 SHALL, on reset during DRAW, drop plot at that edge, emit no done pulse, and accept a start on the first edge after reset falls.

Verification
REQ-030 SHALL pass: full screen (x0=0,y0=0,w=160,h=120,color_in=3'b010) -> 19200 consecutive plot cycles, first (0,0), last (159,119), then one done pulse.
REQ-031 SHALL pass: clipped rectangle (x0=150,y0=115,w=20,h=10) -> 50 plots, x from 150 to 159, y from 115 to 119, no plot with x>=160.
REQ-032 SHALL pass: empty rectangle (w=0) -> no plot, done 2 cycles after the start edge, busy high for 2 cycles.
REQ-033 SHALL pass: 4x2 rectangle with hold=1 for 3 cycles after the 3rd pixel -> 8 plots total, no gaps or duplicates in coordinates, done after the 8th.
REQ-034 SHALL pass: abort during the 5th pixel of a 4x4 rectangle -> plot low next cycle, no done, IDLE; a new start is accepted afterwards.
REQ-035 SHALL pass: start pulsed mid-DRAW with different parameters -> ignored, and the original fill completes unchanged.

Source files
------------

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill sequencer: walks a clipped rectangle in raster order and
// emits one pixel write per cycle toward a 160x120 VGA adapter.
module rect_fill_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] color_in,
  input  logic       hold,
  input  logic       abort,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [7:0] x0_r;
  logic [6:0] y0_r;
  logic [7:0] w_r;
  logic [6:0] h_r;
  logic [2:0] col_r;
  logic [7:0] xe_m1;
  logic [6:0] ye_m1;

  logic [8:0] xe_sum;
  logic [8:0] xe_clip;
  logic [7:0] ye_sum;
  logic [7:0] ye_clip;
  logic [8:0] xe_last;
  logic [7:0] ye_last;
  logic       empty;
  logic       at_xe;
  logic       at_ye;

  always_comb begin
    xe_sum  = {1'b0, x0_r} + {1'b0, w_r};
    ye_sum  = {1'b0, y0_r} + {1'b0, h_r};
    xe_clip = (xe_sum > 9'd160) ? 9'd160 : xe_sum;
    ye_clip = (ye_sum > 8'd120) ? 8'd120 : ye_sum;
    xe_last = xe_clip - 9'd1;
    ye_last = ye_clip - 8'd1;
    empty   = (w_r == 8'd0) || (h_r == 7'd0) || (x0_r >= 8'd160) || (y0_r >= 7'd120);
    at_xe   = (x == xe_m1);
    at_ye   = (y == ye_m1);
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      plot  <= 1'b0;
      x     <= 8'd0;
      y     <= 7'd0;
      color <= 3'd0;
      x0_r  <= 8'd0;
      y0_r  <= 7'd0;
      w_r   <= 8'd0;
      h_r   <= 7'd0;
      col_r <= 3'd0;
      xe_m1 <= 8'd0;
      ye_m1 <= 7'd0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
      plot  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (start && !abort) begin
            x0_r  <= x0;
            y0_r  <= y0;
            w_r   <= w;
            h_r   <= h;
            col_r <= color_in;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (empty) begin
            state <= DONE;
          end else begin
            xe_m1 <= xe_last[7:0];
            ye_m1 <= ye_last[6:0];
            x     <= x0_r;
            y     <= y0_r;
            color <= col_r;
            plot  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          // A pixel shown while hold is high is not taken; it is re-shown once hold drops.
          if (hold) begin
            plot <= 1'b0;
          end else if (!plot) begin
            plot <= 1'b1;
          end else if (at_xe && at_ye) begin
            plot  <= 1'b0;
            state <= DONE;
          end else if (at_xe) begin
            x <= x0_r;
            y <= y + 7'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        DONE: begin
          plot  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          plot  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed self-checking bench for rect_fill_ctrl.
module tb_rect_fill_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] color_in;
  logic       hold;
  logic       abort;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  rect_fill_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color_in (color_in),
    .hold     (hold),
    .abort    (abort),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start, then follows the fill to its end against a raster model.
  // A pixel counts as written in a cycle with plot=1 and hold=0.
  task automatic run_fill(input logic [7:0] ax0, input logic [6:0] ay0,
                          input logic [7:0] aw, input logic [6:0] ah, input logic [2:0] ac,
                          input int hold_after, input int hold_len, input int poke_at,
                          output int n_pix, output int n_err, output int n_done,
                          output int n_cyc, output int first_idx, output int done_idx);
    int xe, ye, ex, ey, hold_left;
    bit hold_used;
    xe = (int'(ax0) + int'(aw) > 160) ? 160 : int'(ax0) + int'(aw);
    ye = (int'(ay0) + int'(ah) > 120) ? 120 : int'(ay0) + int'(ah);
    ex = ax0; ey = ay0;
    n_pix = 0; n_err = 0; n_done = 0; n_cyc = 0; first_idx = -1; done_idx = -1;
    hold_left = 0; hold_used = 0;
    x0 = ax0; y0 = ay0; w = aw; h = ah; color_in = ac; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && n_cyc < 25000) begin
      if (n_cyc == poke_at) begin
        start = 1'b1; x0 = 8'd100; y0 = 7'd50; w = 8'd9; h = 7'd9; color_in = ~ac;
      end else begin
        start = 1'b0;
      end
      if (hold_after > 0 && n_pix == hold_after && !hold_used) begin
        hold_used = 1; hold_left = hold_len;
      end
      hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      if (plot && (x >= 8'd160 || y >= 7'd120)) n_err++;
      if (plot && !hold) begin
        if (first_idx < 0) first_idx = n_cyc;
        if (x != ex[7:0] || y != ey[6:0] || color != ac) n_err++;
        n_pix++;
        ex++;
        if (ex == xe) begin
          ex = ax0; ey++;
        end
      end
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = n_cyc;
      end
      n_cyc++;
      tick();
    end
    start = 1'b0; hold = 1'b0;
  endtask

  int np, ne, nd, nc, fi, di, acc, dn;

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color_in = '0;
    tick(); tick();
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    reset = 1'b0;
    tick();

    // Full screen
    run_fill(8'd0, 7'd0, 8'd160, 7'd120, 3'b010, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("full_pix", np, 19200);
    check("full_err", ne, 0);
    check("full_first_lat", fi, 1);
    check("full_cyc", nc, 19202);
    check("full_done_cnt", nd, 1);
    check("full_done_idx", di, 19201);
    check("full_last_x", x, 159);
    check("full_last_y", y, 119);
    check("full_idle_plot", plot, 0);

    // Clipped at the screen edge
    run_fill(8'd150, 7'd115, 8'd20, 7'd10, 3'b101, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("clip_pix", np, 50);
    check("clip_err", ne, 0);
    check("clip_cyc", nc, 52);
    check("clip_done", nd, 1);

    // Empty rectangles
    run_fill(8'd10, 7'd10, 8'd0, 7'd5, 3'b001, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("empty_w_pix", np, 0);
    check("empty_w_busy_cyc", nc, 2);
    check("empty_w_done_idx", di, 1);
    check("empty_w_done_cnt", nd, 1);
    run_fill(8'd160, 7'd0, 8'd5, 7'd5, 3'b001, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("empty_x0_pix", np, 0);
    check("empty_x0_cyc", nc, 2);
    run_fill(8'd0, 7'd10, 8'd5, 7'd0, 3'b001, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("empty_h_pix", np, 0);

    // 4x2 with a three-cycle stall after the third pixel
    run_fill(8'd10, 7'd20, 8'd4, 7'd2, 3'b110, 3, 3, -1, np, ne, nd, nc, fi, di);
    check("hold_pix", np, 8);
    check("hold_err", ne, 0);
    check("hold_cyc", nc, 14);
    check("hold_done", nd, 1);
    check("hold_done_idx", di, 13);

    // Start pulsed mid-draw must be ignored
    run_fill(8'd5, 7'd5, 8'd3, 7'd3, 3'b011, 0, 0, 4, np, ne, nd, nc, fi, di);
    check("midstart_pix", np, 9);
    check("midstart_err", ne, 0);
    check("midstart_cyc", nc, 11);
    tick();
    check("midstart_idle", busy, 0);

    // Abort during the fifth pixel of a 4x4
    x0 = 8'd0; y0 = 7'd0; w = 8'd4; h = 7'd4; color_in = 3'b111; start = 1'b1;
    tick();
    start = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (plot && acc == 4) begin
        abort = 1'b1;
        break;
      end
      if (plot) acc++;
      tick();
    end
    check("abort_reached", acc, 4);
    tick();
    abort = 1'b0;
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      tick();
    end
    check("abort_no_done", dn, 0);
    run_fill(8'd20, 7'd30, 8'd2, 7'd1, 3'b100, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("abort_restart_pix", np, 2);
    check("abort_restart_err", ne, 0);

    // Reset in the middle of drawing
    x0 = 8'd0; y0 = 7'd0; w = 8'd10; h = 7'd10; color_in = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rdraw_pre_plot", plot, 1);
    reset = 1'b1;
    tick();
    check("rdraw_plot", plot, 0);
    check("rdraw_busy", busy, 0);
    check("rdraw_done", done, 0);
    check("rdraw_x", x, 0);
    reset = 1'b0;
    run_fill(8'd3, 7'd4, 8'd2, 7'd2, 3'b010, 0, 0, -1, np, ne, nd, nc, fi, di);
    check("rdraw_restart_pix", np, 4);
    check("rdraw_restart_cyc", nc, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
